// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: interlock FSM states, register-specifier width
// and the control-word encoding used for NOP/bubble injection.
package pipe_pkg;

  localparam int REG_W = 4;

  typedef enum logic [2:0] {
    RUN,
    LOAD_STALL,
    CTRL_HOLD,
    DRAIN,
    HALTED
  } hz_state_t;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_bubble;
    logic pc_hazard;
    logic halted;
  } hz_ctrl_t;

  // A NOP is all control fields zero
  localparam hz_ctrl_t HZ_NOP = '0;

endpackage

// File: rtl/hazard_cmp.sv
// Combinational load-use compare: an ID source matching a non-zero load
// destination in EX. Shared with the forwarding unit.
module hazard_cmp
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] rs_1,
  input  logic [REG_W-1:0] rs_2,
  input  logic             uses_rs_1,
  input  logic             uses_rs_2,
  input  logic             mem_read,
  input  logic [REG_W-1:0] rd,
  output logic             luh
);

  logic [1:0][REG_W-1:0] rs_v;
  logic [1:0]            uses_v;
  logic [1:0]            match;

  assign rs_v   = {rs_2, rs_1};
  assign uses_v = {uses_rs_2, uses_rs_1};

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_src
    assign match[gi] = uses_v[gi] & (rs_v[gi] == rd);
  end

  // Register 0 is hardwired, so a load targeting it never interlocks
  assign luh = mem_read & (rd != '0) & (|match);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline interlock controller: load-use stall, call/ret hold, taken-branch
// flush and HALT drain. Optional stall counter enabled by HAZARD_STATS_EN.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CTRL_WAIT = 2,
  parameter int DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs_1,
  input  logic [REG_W-1:0] id_rs_2,
  input  logic             id_uses_rs_1,
  input  logic             id_uses_rs_2,
  input  logic             id_call,
  input  logic             id_ret,
  input  logic             id_halt,
  input  logic             ex_MemRead,
  input  logic [REG_W-1:0] ex_reg_rd,
  input  logic             ex_branch_taken,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             PC_hazard,
`ifdef HAZARD_STATS_EN
  output logic             halted,
  output logic [15:0]      stall_cnt
`else
  output logic             halted
`endif
);

  localparam logic [2:0] CTRL_LOAD  = 3'(CTRL_WAIT - 1);
  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYC - 1);

  hz_state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  hz_ctrl_t   ctrl;
  logic       luh;

  hazard_cmp u_cmp (
    .rs_1      (id_rs_1),
    .rs_2      (id_rs_2),
    .uses_rs_1 (id_uses_rs_1),
    .uses_rs_2 (id_uses_rs_2),
    .mem_read  (ex_MemRead),
    .rd        (ex_reg_rd),
    .luh       (luh)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        // A taken branch makes the ID instruction wrong-path, so it masks ID events
        if (ex_branch_taken) begin
          state_d = RUN;
        end else if (luh) begin
          state_d = LOAD_STALL;
        end else if (id_call | id_ret) begin
          cnt_d   = CTRL_LOAD;
          state_d = CTRL_HOLD;
        end else if (id_halt) begin
          cnt_d   = DRAIN_LOAD;
          state_d = DRAIN;
        end
      end
      LOAD_STALL: state_d = RUN;
      CTRL_HOLD: begin
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - 3'd1;
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = HALTED;
        else             cnt_d   = cnt_q - 3'd1;
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    ctrl = HZ_NOP;
    if (rst_n) begin
      unique case (state_q)
        RUN: begin
          if (ex_branch_taken) begin
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_bubble = 1'b1;
          end else if (luh) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.ifid_stall  = 1'b1;
            ctrl.idex_bubble = 1'b1;
          end else if (id_call | id_ret) begin
            // The call/ret itself proceeds into ID/EX; only younger fetches are dropped
            ctrl.pc_hazard  = 1'b1;
            ctrl.pc_stall   = 1'b1;
            ctrl.ifid_flush = 1'b1;
          end else if (id_halt) begin
            ctrl.pc_stall   = 1'b1;
            ctrl.ifid_flush = 1'b1;
          end
        end
        CTRL_HOLD: begin
          ctrl.pc_hazard   = 1'b1;
          ctrl.pc_stall    = 1'b1;
          ctrl.ifid_flush  = 1'b1;
          ctrl.idex_bubble = 1'b1;
        end
        DRAIN: begin
          ctrl.pc_stall    = 1'b1;
          ctrl.ifid_flush  = 1'b1;
          ctrl.idex_bubble = 1'b1;
        end
        HALTED: begin
          ctrl.pc_stall   = 1'b1;
          ctrl.ifid_stall = 1'b1;
          ctrl.halted     = 1'b1;
        end
        default: ctrl = HZ_NOP;
      endcase
    end
  end

  assign pc_stall    = ctrl.pc_stall;
  assign ifid_stall  = ctrl.ifid_stall;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_bubble = ctrl.idex_bubble;
  assign PC_hazard   = ctrl.pc_hazard;
  assign halted      = ctrl.halted;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Halted cycles are excluded so the count reflects lost issue slots only
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ctrl.pc_stall && (state_q != HALTED) && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// stimulus against a schedule-based reference model. Stats checks under HAZARD_STATS_EN.
module tb_hazard_ctrl;

  localparam int CW = 2;
  localparam int DC = 3;

  // {pc_stall, ifid_stall, ifid_flush, idex_bubble, PC_hazard, halted}
  localparam logic [5:0] O_NONE   = 6'b000000;
  localparam logic [5:0] O_LUH    = 6'b110100;
  localparam logic [5:0] O_BR     = 6'b001100;
  localparam logic [5:0] O_CALL   = 6'b101010;
  localparam logic [5:0] O_HOLD   = 6'b101110;
  localparam logic [5:0] O_HALT1  = 6'b101000;
  localparam logic [5:0] O_DRAIN  = 6'b101100;
  localparam logic [5:0] O_HALTED = 6'b110001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] id_rs_1, id_rs_2, ex_reg_rd;
  logic       id_uses_rs_1, id_uses_rs_2, id_call, id_ret, id_halt;
  logic       ex_MemRead, ex_branch_taken;
  logic       pc_stall, ifid_stall, ifid_flush, idex_bubble, PC_hazard, halted;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CTRL_WAIT(CW), .DRAIN_CYC(DC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs_1         (id_rs_1),
    .id_rs_2         (id_rs_2),
    .id_uses_rs_1    (id_uses_rs_1),
    .id_uses_rs_2    (id_uses_rs_2),
    .id_call         (id_call),
    .id_ret          (id_ret),
    .id_halt         (id_halt),
    .ex_MemRead      (ex_MemRead),
    .ex_reg_rd       (ex_reg_rd),
    .ex_branch_taken (ex_branch_taken),
    .pc_stall        (pc_stall),
    .ifid_stall      (ifid_stall),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .PC_hazard       (PC_hazard),
`ifdef HAZARD_STATS_EN
    .halted          (halted),
    .stall_cnt       (stall_cnt)
`else
    .halted          (halted)
`endif
  );

  logic [5:0] outs;
  assign outs = {pc_stall, ifid_stall, ifid_flush, idex_bubble, PC_hazard, halted};

  task automatic drv(input logic [3:0] rs1, input logic [3:0] rs2, input logic u1, input logic u2,
                     input logic call, input logic ret, input logic halt, input logic mr,
                     input logic [3:0] rd, input logic br);
    id_rs_1 = rs1; id_rs_2 = rs2; id_uses_rs_1 = u1; id_uses_rs_2 = u2;
    id_call = call; id_ret = ret; id_halt = halt;
    ex_MemRead = mr; ex_reg_rd = rd; ex_branch_taken = br;
  endtask

  task automatic clr();
    drv(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Reference model: a queue of outputs already committed for future cycles.
  logic [5:0]  sched_q[$];
  bit          halted_m;
  bit          drain_m;
  int unsigned scnt_m;

  task automatic model_clear();
    sched_q.delete();
    halted_m = 1'b0;
    drain_m  = 1'b0;
    scnt_m   = 0;
  endtask

  task automatic model_step(output logic [5:0] e);
    bit luh_m;
    luh_m = ex_MemRead && (ex_reg_rd != 0) &&
            ((id_uses_rs_1 && id_rs_1 == ex_reg_rd) || (id_uses_rs_2 && id_rs_2 == ex_reg_rd));
    if (!rst_n) begin
      e = O_NONE;
      model_clear();
      return;
    end
    if (halted_m)                  e = O_HALTED;
    else if (sched_q.size() > 0)   e = sched_q.pop_front();
    else if (ex_branch_taken)      e = O_BR;
    else if (luh_m) begin
      e = O_LUH;
      sched_q.push_back(O_NONE);
    end else if (id_call || id_ret) begin
      e = O_CALL;
      for (int k = 0; k < CW; k++) sched_q.push_back(O_HOLD);
    end else if (id_halt) begin
      e = O_HALT1;
      for (int k = 0; k < DC; k++) sched_q.push_back(O_DRAIN);
      drain_m = 1'b1;
    end else                       e = O_NONE;
    if (e[5] && !halted_m && scnt_m < 65535) scnt_m++;
    if (drain_m && e == O_DRAIN && sched_q.size() == 0) begin
      halted_m = 1'b1;
      drain_m  = 1'b0;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      rst_n = 1'b0;
      drv(4'd4, 4'd4, 1'b1, 1'b1, 1'(i == 0), 1'(i == 1), 1'b1, 1'b1, 4'd4, 1'(i == 2));
      @(negedge clk);
      n_tests++;
      if (outs !== O_NONE) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got %b expected %b", i, outs, O_NONE);
      end else $display("[TB] reset_outputs cycle %0d outs=%b", i, outs);
`ifdef HAZARD_STATS_EN
      n_tests++;
      if (i > 0 && stall_cnt !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
      end
`endif
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    clr();
  endtask

  task automatic test_load_use();
    logic [5:0] exp_v [8] = '{O_LUH, O_NONE, O_NONE, O_NONE, O_NONE, O_LUH, O_NONE, O_NONE};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      case (i)
        0, 1:    drv(4'd0, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0);
        3:       drv(4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        4:       drv(4'd4, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0);
        5:       drv(4'd4, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0);
        7:       drv(4'd4, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0);
        default: clr();
      endcase
      @(negedge clk);
      n_tests++;
      if (outs !== exp_v[i]) begin
        n_fail++;
        $display("FAIL load_use cycle %0d: got %b expected %b", i, outs, exp_v[i]);
      end else $display("[TB] load_use cycle %0d outs=%b", i, outs);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ctrl_hold();
    logic [5:0] exp_v [4] = '{O_CALL, O_HOLD, O_HOLD, O_NONE};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 0)      drv(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      else if (i < 3)  drv(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
      else             clr();
      @(negedge clk);
      n_tests++;
      if (outs !== exp_v[i]) begin
        n_fail++;
        $display("FAIL ctrl_hold cycle %0d: got %b expected %b", i, outs, exp_v[i]);
      end else $display("[TB] ctrl_hold cycle %0d outs=%b", i, outs);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_priority();
    logic [5:0] exp_v [7] = '{O_BR, O_NONE, O_LUH, O_NONE, O_CALL, O_HOLD, O_HOLD};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      case (i)
        0:       drv(4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd5, 1'b1);
        2, 3, 4: drv(4'd5, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'(i == 2), 4'd5, 1'b0);
        default: clr();
      endcase
      @(negedge clk);
      n_tests++;
      if (outs !== exp_v[i]) begin
        n_fail++;
        $display("FAIL priority cycle %0d: got %b expected %b", i, outs, exp_v[i]);
      end else $display("[TB] priority cycle %0d outs=%b", i, outs);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    logic [5:0] exp_v [12] = '{O_HALT1, O_DRAIN, O_DRAIN, O_DRAIN, O_HALTED, O_HALTED,
                               O_HALTED, O_HALTED, O_NONE, O_NONE, O_LUH, O_NONE};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      rst_n = (i != 8);
      if (i == 0)                drv(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
      else if (i >= 4 && i < 8)  drv(4'd2, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 1'b1);
      else if (i == 10)          drv(4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
      else                       clr();
      @(negedge clk);
      n_tests++;
      if (outs !== exp_v[i]) begin
        n_fail++;
        $display("FAIL halt cycle %0d: got %b expected %b", i, outs, exp_v[i]);
      end else $display("[TB] halt cycle %0d outs=%b", i, outs);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_hold();
    logic [5:0] exp_v [5] = '{O_CALL, O_HOLD, O_NONE, O_NONE, O_NONE};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rst_n = (i != 2);
      if (i == 0) drv(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      else        clr();
      @(negedge clk);
      n_tests++;
      if (outs !== exp_v[i]) begin
        n_fail++;
        $display("FAIL reset_mid_hold cycle %0d: got %b expected %b", i, outs, exp_v[i]);
      end else $display("[TB] reset_mid_hold cycle %0d outs=%b", i, outs);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 0 || i == 2) drv(4'd7, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0);
      else if (i == 4)      drv(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      else                  clr();
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_tests++;
    if (stall_cnt !== 16'd5) begin
      n_fail++;
      $display("FAIL stall_cnt_mix: got %0d expected 5", stall_cnt);
    end else $display("[TB] stall_cnt_mix stall_cnt=%0d", stall_cnt);
    drv(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    repeat (70000) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if (stall_cnt !== 16'hFFFF) begin
        n_fail++;
        $display("FAIL stall_cnt_sat %0d: got %h expected ffff", i, stall_cnt);
      end else $display("[TB] stall_cnt_sat %0d stall_cnt=%h", i, stall_cnt);
      @(posedge clk); #1;
    end
    clr();
  endtask
`endif

  task automatic test_random();
    logic [5:0] e;
    int         bad = 0;
    int         n   = 3000;
    do_reset();
    model_clear();
    for (int i = 0; i < n; i++) begin
      rst_n = ($urandom % 100) != 0;
      drv(4'($urandom % 4), 4'($urandom % 4), 1'($urandom % 2), 1'($urandom % 2),
          1'(($urandom % 10) == 0), 1'(($urandom % 10) == 0), 1'(($urandom % 40) == 0),
          1'(($urandom % 3) == 0), 4'($urandom % 4), 1'(($urandom % 6) == 0));
      @(negedge clk);
`ifdef HAZARD_STATS_EN
      n_tests++;
      if (stall_cnt !== 16'(scnt_m)) begin
        n_fail++; bad++;
        $display("FAIL random_stall_cnt cycle %0d: got %0d expected %0d", i, stall_cnt, scnt_m);
      end
`endif
      model_step(e);
      n_tests++;
      if (outs !== e) begin
        n_fail++; bad++;
        $display("FAIL random cycle %0d: got %b expected %b", i, outs, e);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    $display("[TB] random: %0d cycles, %0d mismatching", n, bad);
  endtask

  initial begin
    clr();
    test_reset();
    test_load_use();
    test_ctrl_hold();
    test_priority();
    test_halt();
    test_reset_mid_hold();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
